// File: rtl/fscale_pow2.sv
// fscale_pow2: multi-lane pipelined ldexp unit computing x * 2^k per lane,
// with a shared signed k, subnormal normalisation, and overflow/underflow
// saturation flags. The two register stages use valid/ready handshaking.
module fscale_pow2 #(
    parameter int I_EXP   = 8,
    parameter int I_MNT   = 7,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*I_DATA-1:0] in_data,
    input  logic [SHIFT_W-1:0]      in_shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*I_DATA-1:0] out_data,
    output logic [LANES-1:0]        out_ovf,
    output logic [LANES-1:0]        out_unf
);

    // The effective exponent is signed and two bits wider than the stored
    // exponent, so it can hold both exp+k overflow and deep subnormal values.
    localparam int EW = I_EXP + 2;
    localparam logic [I_EXP-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] EMAX     = EW'((2 ** I_EXP) - 1);
    localparam logic signed [EW-1:0] EONE     = EW'(1);
    localparam logic [EW-1:0]        SA_FLUSH = EW'(I_MNT + 1);

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv;

    // S1 combinational results
    logic [EW-1:0]    kext;
    logic [LANES-1:0] c_sign, c_pass;
    logic [I_EXP-1:0] c_exp [LANES];
    logic [I_MNT-1:0] c_mnt [LANES];
    logic [I_MNT-1:0] c_mn  [LANES];
    logic [EW-1:0]    c_sh  [LANES];
    logic [EW-1:0]    c_e   [LANES];

    // S1 registers
    logic [LANES-1:0] s1_sign, s1_pass;
    logic [I_EXP-1:0] s1_exp [LANES];
    logic [I_MNT-1:0] s1_mnt [LANES];
    logic [I_MNT-1:0] s1_mn  [LANES];
    logic [EW-1:0]    s1_e   [LANES];

    // S2 combinational results
    logic signed [EW-1:0] r_e    [LANES];
    logic [EW-1:0]        r_sa   [LANES];
    logic [I_MNT:0]       r_wide [LANES];
    logic [LANES*I_DATA-1:0] r_data;
    logic [LANES-1:0]        r_ovf, r_unf;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Unpack and classify each lane, normalise subnormals, form exponent E.
    always_comb begin
        kext = {{(EW-SHIFT_W){in_shift[SHIFT_W-1]}}, in_shift};
        for (int i = 0; i < LANES; i++) begin
            c_sign[i] = in_data[i*I_DATA + I_DATA - 1];
            c_exp[i]  = in_data[i*I_DATA + I_MNT +: I_EXP];
            c_mnt[i]  = in_data[i*I_DATA +: I_MNT];
            c_pass[i] = (c_exp[i] == EXP_ONES) ||
                        (c_exp[i] == '0 && c_mnt[i] == '0);
            // Distance the highest set mantissa bit must move to reach the
            // hidden-bit position; the last (highest) set bit wins.
            c_sh[i] = '0;
            for (int b = 0; b < I_MNT; b++) begin
                if (c_mnt[i][b]) c_sh[i] = EW'(I_MNT - b);
            end
            if (c_exp[i] != '0) begin
                c_e[i]  = {2'b00, c_exp[i]} + kext;
                c_mn[i] = c_mnt[i];
            end else begin
                c_e[i]  = EW'(1) - c_sh[i] + kext;
                c_mn[i] = c_mnt[i] << c_sh[i];
            end
        end
    end

    // S1 register: captures a beat whenever it is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= c_sign;
                s1_pass <= c_pass;
                for (int i = 0; i < LANES; i++) begin
                    s1_exp[i] <= c_exp[i];
                    s1_mnt[i] <= c_mnt[i];
                    s1_mn[i]  <= c_mn[i];
                    s1_e[i]   <= c_e[i];
                end
            end
        end
    end

    // Build the final encoding: pass-through, saturate, normal or denormalise.
    always_comb begin
        r_data = '0;
        r_ovf  = '0;
        r_unf  = '0;
        for (int i = 0; i < LANES; i++) begin
            r_e[i]    = s1_e[i];
            r_sa[i]   = EONE - r_e[i];
            r_wide[i] = {1'b1, s1_mn[i]} >> r_sa[i];
            if (s1_pass[i]) begin
                r_data[i*I_DATA +: I_DATA] = {s1_sign[i], s1_exp[i], s1_mnt[i]};
            end else if (r_e[i] >= EMAX) begin
                r_data[i*I_DATA +: I_DATA] = {s1_sign[i], EXP_ONES, {I_MNT{1'b0}}};
                r_ovf[i] = 1'b1;
            end else if (r_e[i] >= EONE) begin
                r_data[i*I_DATA +: I_DATA] = {s1_sign[i], s1_e[i][I_EXP-1:0], s1_mn[i]};
            end else begin
                if (r_sa[i] >= SA_FLUSH) r_wide[i] = '0;
                r_data[i*I_DATA +: I_DATA] = {s1_sign[i], {I_EXP{1'b0}}, r_wide[i][I_MNT-1:0]};
                r_unf[i] = (r_wide[i][I_MNT-1:0] == '0);
            end
        end
    end

    // S2 register drives the outputs; bubbles load zeroed data and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= '0;
            out_unf  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            out_data <= s1_valid ? r_data : '0;
            out_ovf  <= s1_valid ? r_ovf  : '0;
            out_unf  <= s1_valid ? r_unf  : '0;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_fscale_pow2.sv
// Testbench for fscale_pow2: directed test-plan beats, a backpressured
// stream, a mid-stream reset and a randomised stream against a value model.
module tb_fscale_pow2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_ovf;
    logic [3:0]  out_unf;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  ovf;
        logic [3:0]  unf;
    } beat_t;

    beat_t expQ[$];
    int checks = 0;
    int errors = 0;
    int received = 0;

    fscale_pow2 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value-level model: lane = M * 2^p, scale p by k, re-encode with truncation.
    function automatic logic [17:0] scaleLane(input logic [15:0] x, input int k);
        int e, m, bigM, p, n, be, sft, mm, frac;
        logic [7:0] beb;
        logic [6:0] fb;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 255 || (e == 0 && m == 0)) return {2'b00, x};
        if (e != 0) begin bigM = 128 + m; p = e - 134; end
        else        begin bigM = m;       p = -133;    end
        p = p + k;
        n = 0;
        for (int b = 0; b < 8; b++) if (((bigM >> b) & 1) == 1) n = b;
        be = n + p + 127;
        if (be >= 255) return {2'b10, x[15], 8'hFF, 7'h00};
        if (be >= 1) begin
            frac = (bigM << (7 - n)) & 127;
            beb = be[7:0];
            fb = frac[6:0];
            return {2'b00, x[15], beb, fb};
        end
        sft = p + 133;
        if (sft >= 0)       mm = bigM << sft;
        else if (-sft >= 31) mm = 0;
        else                mm = bigM >> (-sft);
        if (mm == 0) return {2'b01, x[15], 15'h0000};
        fb = mm[6:0];
        return {2'b00, x[15], 8'h00, fb};
    endfunction

    function automatic beat_t model(input logic [63:0] d, input logic [5:0] k);
        beat_t r;
        logic [17:0] l;
        for (int i = 0; i < 4; i++) begin
            l = scaleLane(d[i*16 +: 16], int'($signed(k)));
            r.data[i*16 +: 16] = l[15:0];
            r.ovf[i] = l[17];
            r.unf[i] = l[16];
        end
        return r;
    endfunction

    function automatic logic [15:0] randLane();
        logic [7:0] e;
        logic [6:0] m;
        case ($urandom_range(0, 5))
            0: e = 8'h00;
            1: e = 8'h01;
            2: e = 8'hFE;
            3: e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // One directed beat into an empty pipeline with out_ready=1; checks latency.
    task automatic applyStimulus(input string tag, input logic [63:0] d, input logic [5:0] k,
                                 input logic [63:0] expData, input logic [3:0] expOvf,
                                 input logic [3:0] expUnf);
        in_data = d; in_shift = k; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        checkOutput({tag, "_lat2_valid"}, 64'(out_valid), 64'(1));
        checkOutput({tag, "_data"}, out_data, expData);
        checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(expOvf));
        checkOutput({tag, "_unf"}, 64'(out_unf), 64'(expUnf));
        @(posedge clk); #1;
    endtask

    // One cycle of streaming with scoreboarding; handshakes sampled mid-cycle.
    task automatic tick();
        beat_t e;
        logic wasReset;
        #3;
        wasReset = !rst_n;
        if (rst_n) begin
            if (in_valid && in_ready) expQ.push_back(model(in_data, in_shift));
            if (out_valid && out_ready) begin
                received++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(out_valid), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("stream_data", out_data, e.data);
                    checkOutput("stream_ovf", 64'(out_ovf), 64'(e.ovf));
                    checkOutput("stream_unf", 64'(out_unf), 64'(e.unf));
                end
            end
        end
        @(posedge clk); #1;
        if (wasReset) expQ.delete();
    endtask

    initial begin
        logic [63:0] heldData;
        logic        stalledPrev;
        logic        sawInReadyLow;
        int          sent;

        $display("[TB] start");
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", out_data, 64'(0));
        checkOutput("rst_out_ovf", 64'(out_ovf), 64'(0));
        checkOutput("rst_out_unf", 64'(out_unf), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed test-plan beats (lane 0 in the low bits)
        applyStimulus("scale_k3", {4{16'h3F80}}, 6'd3, {4{16'h4100}}, 4'b0000, 4'b0000);
        applyStimulus("div2_km1", {16'h80FF, 16'h10FF, 16'h00FF, 16'h007F}, 6'h3F,
                      {16'h807F, 16'h107F, 16'h007F, 16'h003F}, 4'b0000, 4'b0000);
        applyStimulus("sat_kp1", {16'h7FC0, 16'h0001, 16'hFF00, 16'h7F00}, 6'd1,
                      {16'h7FC0, 16'h0002, 16'hFF80, 16'h7F80}, 4'b0011, 4'b0000);
        applyStimulus("sat_km1", {16'h7FC0, 16'h0001, 16'hFF00, 16'h7F00}, 6'h3F,
                      {16'h7FC0, 16'h0000, 16'hFE80, 16'h7E80}, 4'b0000, 4'b0100);
        applyStimulus("subn_kp1", {4{16'h0040}}, 6'd1, {4{16'h0080}}, 4'b0000, 4'b0000);
        applyStimulus("subn_kp8", {4{16'h0001}}, 6'd8, {4{16'h0100}}, 4'b0000, 4'b0000);
        applyStimulus("zero_sign", {16'h8000, 16'h0000, 16'h8000, 16'h0000}, 6'h20,
                      {16'h8000, 16'h0000, 16'h8000, 16'h0000}, 4'b0000, 4'b0000);

        // k=0 identity on random encodings
        for (int t = 0; t < 6; t++) begin
            logic [63:0] d;
            d = {randLane(), randLane(), randLane(), randLane()};
            applyStimulus("identity_k0", d, 6'd0, d, 4'b0000, 4'b0000);
        end

        // Backpressure: 8 beats, out_ready low for cycles 3..6
        sent = 0; received = 0; stalledPrev = 1'b0; sawInReadyLow = 1'b0; heldData = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (in_valid && in_ready) sent++;
            in_valid  = (sent < 8);
            in_data   = {randLane(), randLane(), randLane(), randLane()};
            in_shift  = 6'($urandom);
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (!in_ready) sawInReadyLow = 1'b1;
            if (stalledPrev) checkOutput("stall_stable", out_data, heldData);
            stalledPrev = out_valid && !out_ready;
            heldData = out_data;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_in_ready_fell", 64'(sawInReadyLow), 64'(1));
        checkOutput("bp_received", 64'(received), 64'(8));
        checkOutput("bp_queue_empty", 64'(expQ.size()), 64'(0));

        // Randomised stream with a one-cycle reset in the middle
        received = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {randLane(), randLane(), randLane(), randLane()};
            in_shift  = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = (cyc != 150);
            tick();
            if (cyc == 150) begin
                checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
                checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) tick();
        checkOutput("rand_queue_empty", 64'(expQ.size()), 64'(0));
        checkOutput("rand_out_idle", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
